// File: rtl/profiler_window_controller.sv
// Window/freeze/dump sequencer for the instruction profiler.
// The profiler stays enabled outside IDLE; freezing is done only by gating the issue strobe.
module profiler_window_controller #(
  parameter int unsigned NUM_COUNTERS = 11,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned WIN_W        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [WIN_W-1:0]                cmd_window,
  input  logic                            instruction_issued_in,
  output logic                            instruction_issued_out,
  output logic                            prof_enable,
  input  logic [NUM_COUNTERS*CNT_W-1:0]   counters_in,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [CNT_W-1:0]                dump_data,
  output logic [$clog2(NUM_COUNTERS)-1:0] dump_index,
  output logic                            dump_last,
  output logic                            busy,
  output logic                            window_done,
  output logic [WIN_W-1:0]                cycles_elapsed
);

  localparam int unsigned IDX_W = $clog2(NUM_COUNTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COUNTERS - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DUMP = 2'd3;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  logic [1:0]       state_q,     state_d;
  logic [WIN_W-1:0] remaining_q, remaining_d;
  logic [WIN_W-1:0] elapsed_q,   elapsed_d;
  logic             done_q,      done_d;
  logic             dv_q,        dv_d;
  logic [IDX_W-1:0] di_q,        di_d;
  logic [CNT_W-1:0] dd_q,        dd_d;
  logic             dl_q,        dl_d;

  logic             accept;
  logic [WIN_W-1:0] elapsed_inc;
  logic [IDX_W-1:0] di_nxt;
  logic [CNT_W-1:0] cnt_arr [NUM_COUNTERS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      cnt_arr[i] = counters_in[i*CNT_W +: CNT_W];
    end
  end

  assign cmd_ready              = (state_q != S_DUMP);
  assign accept                 = cmd_valid & cmd_ready;
  assign prof_enable            = (state_q != S_IDLE);
  assign instruction_issued_out = instruction_issued_in & (state_q == S_RUN);
  assign busy                   = (state_q == S_RUN) | (state_q == S_DUMP);
  assign window_done            = done_q;
  assign cycles_elapsed         = elapsed_q;
  assign dump_valid             = dv_q;
  assign dump_index             = di_q;
  assign dump_data              = dd_q;
  assign dump_last              = dl_q;

  assign elapsed_inc = (elapsed_q == '1) ? elapsed_q : elapsed_q + WIN_ONE;
  assign di_nxt      = di_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    elapsed_d   = elapsed_q;
    done_d      = 1'b0;
    dv_d        = dv_q;
    di_d        = di_q;
    dd_d        = dd_q;
    dl_d        = dl_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && cmd_op == OP_START) begin
          state_d     = S_RUN;
          remaining_d = cmd_window;
          elapsed_d   = '0;
        end
      end
      S_RUN: begin
        elapsed_d = elapsed_inc;
        if (remaining_q != '0) remaining_d = remaining_q - WIN_ONE;
        // An accepted STOP/CLEAR/START overrides expiry on the same edge and suppresses window_done.
        if (accept && cmd_op == OP_STOP) begin
          state_d = S_HOLD;
        end else if (accept && cmd_op == OP_CLEAR) begin
          state_d     = S_IDLE;
          elapsed_d   = '0;
          remaining_d = '0;
        end else if (accept && cmd_op == OP_START) begin
          remaining_d = cmd_window;
        end else if (remaining_q == WIN_ONE) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept && cmd_op == OP_START) begin
          state_d     = S_RUN;
          remaining_d = cmd_window;
        end else if (accept && cmd_op == OP_DUMP) begin
          state_d = S_DUMP;
          dv_d    = 1'b1;
          di_d    = '0;
          dd_d    = cnt_arr[0];
          dl_d    = (LAST_IDX == '0);
        end else if (accept && cmd_op == OP_CLEAR) begin
          state_d = S_IDLE;
        end
      end
      S_DUMP: begin
        if (dv_q && dump_ready) begin
          if (dl_q) begin
            state_d = S_HOLD;
            dv_d    = 1'b0;
            di_d    = '0;
            dl_d    = 1'b0;
          end else begin
            di_d = di_nxt;
            dd_d = cnt_arr[di_nxt];
            dl_d = (di_nxt == LAST_IDX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      elapsed_q   <= '0;
      done_q      <= 1'b0;
      dv_q        <= 1'b0;
      di_q        <= '0;
      dd_q        <= '0;
      dl_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      elapsed_q   <= elapsed_d;
      done_q      <= done_d;
      dv_q        <= dv_d;
      di_q        <= di_d;
      dd_q        <= dd_d;
      dl_q        <= dl_d;
    end
  end

endmodule

// File: tb/tb_profiler_window_controller.sv
// Directed bench for profiler_window_controller with a one-counter profiler stub on index 0.
module tb_profiler_window_controller;

  localparam int unsigned NC = 11;
  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_START = 2'b01;
  localparam logic [1:0] OP_STOP  = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [31:0]   cmd_window;
  logic          issue_in;
  logic          issue_out;
  logic          prof_enable;
  logic [NC*32-1:0] counters_in;
  logic          dump_valid;
  logic          dump_ready;
  logic [31:0]   dump_data;
  logic [3:0]    dump_index;
  logic          dump_last;
  logic          busy;
  logic          window_done;
  logic [31:0]   cycles_elapsed;

  int checks = 0;
  int errors = 0;

  logic [31:0] cnt0 = '0;
  int          gated_cnt = 0;
  int          hs_n = 0;
  logic [3:0]  hs_idx [64];
  int          base;

  always #5 clk = ~clk;

  profiler_window_controller #(.NUM_COUNTERS(NC), .CNT_W(32), .WIN_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_window(cmd_window),
    .instruction_issued_in(issue_in), .instruction_issued_out(issue_out),
    .prof_enable(prof_enable), .counters_in(counters_in),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .dump_last(dump_last),
    .busy(busy), .window_done(window_done), .cycles_elapsed(cycles_elapsed)
  );

  // Profiler stub: counter 0 counts gated issues, cleared whenever enable is low.
  always @(posedge clk) begin
    if (!prof_enable) cnt0 <= '0;
    else if (issue_out) cnt0 <= cnt0 + 32'd1;
  end

  always @(posedge clk) begin
    if (issue_out) gated_cnt++;
    if (dump_valid && dump_ready && hs_n < 64) begin
      hs_idx[hs_n] = dump_index;
      hs_n++;
    end
  end

  always_comb begin
    counters_in = '0;
    counters_in[31:0] = cnt0;
    for (int i = 1; i < NC; i++) counters_in[i*32 +: 32] = 32'hA000_0000 + 32'(i);
  end

  function automatic logic [31:0] word(input int unsigned i, input logic [31:0] c0);
    return (i == 0) ? c0 : 32'hA000_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [31:0] w);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_window = w;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_CLEAR; cmd_window = '0;
    issue_in = 1'b0; dump_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_prof_enable", prof_enable, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_window_done", window_done, 0);
    chk("rst_elapsed", cycles_elapsed, 0);
    rst = 1'b0;
    tick();

    // 1: bounded window of 10 with issue held high
    issue_in = 1'b1;
    cmd(OP_START, 32'd10);
    base = gated_cnt;
    chk("t1_gate_open", issue_out, 1);
    chk("t1_busy", busy, 1);
    repeat (9) tick();
    chk("t1_done_early", window_done, 0);
    chk("t1_elapsed9", cycles_elapsed, 9);
    tick();
    chk("t1_done_pulse", window_done, 1);
    chk("t1_elapsed10", cycles_elapsed, 10);
    chk("t1_hold_busy", busy, 0);
    chk("t1_gated_strobes", gated_cnt - base, 10);
    chk("t1_gate_closed", issue_out, 0);
    tick();
    chk("t1_done_one_cycle", window_done, 0);
    chk("t1_strobes_frozen", gated_cnt - base, 10);
    chk("t1_cnt0", cnt0, 10);

    // 2: unbounded window, 7 strobes, STOP, full dump
    cmd(OP_CLEAR, 32'd0);
    chk("t2_clear_enable", prof_enable, 0);
    tick();
    chk("t2_cnt0_cleared", cnt0, 0);
    issue_in = 1'b0;
    cmd(OP_START, 32'd0);
    chk("t2_elapsed0", cycles_elapsed, 0);
    issue_in = 1'b1;
    repeat (7) tick();
    issue_in = 1'b0;
    repeat (2) tick();
    cmd(OP_STOP, 32'd0);
    chk("t2_hold_busy", busy, 0);
    chk("t2_no_done", window_done, 0);
    chk("t2_elapsed10", cycles_elapsed, 10);
    chk("t2_cnt0", cnt0, 7);
    base = hs_n;
    dump_ready = 1'b1;
    cmd(OP_DUMP, 32'd0);
    chk("t2_cmd_ready_dump", cmd_ready, 0);
    for (int unsigned i = 0; i < NC; i++) begin
      chk("t2_valid", dump_valid, 1);
      chk("t2_index", dump_index, i);
      chk("t2_data", dump_data, word(i, 32'd7));
      chk("t2_last", dump_last, (i == NC - 1) ? 1 : 0);
      tick();
    end
    chk("t2_valid_end", dump_valid, 0);
    chk("t2_back_hold", busy, 0);
    chk("t2_cmd_ready_end", cmd_ready, 1);
    chk("t2_handshakes", hs_n - base, NC);

    // 3: stall with ready 1,0,0,1
    dump_ready = 1'b0;
    base = hs_n;
    cmd(OP_DUMP, 32'd0);
    chk("t3_idx0", dump_index, 0);
    dump_ready = 1'b1;
    tick();
    chk("t3_idx1", dump_index, 1);
    dump_ready = 1'b0;
    tick();
    chk("t3_stall_idx", dump_index, 1);
    chk("t3_stall_data", dump_data, word(1, 32'd7));
    chk("t3_stall_cmd_ready", cmd_ready, 0);
    tick();
    chk("t3_stall2_idx", dump_index, 1);
    chk("t3_stall2_valid", dump_valid, 1);
    chk("t3_stall2_cmd_ready", cmd_ready, 0);
    dump_ready = 1'b1;
    tick();
    chk("t3_idx2", dump_index, 2);
    for (int k = 0; k < 20 && dump_valid; k++) tick();
    chk("t3_dump_finished", dump_valid, 0);
    chk("t3_handshakes", hs_n - base, NC);
    for (int k = 0; k < NC; k++) chk("t3_hs_order", hs_idx[base + k], k);

    // 4: STOP on the expiry edge
    cmd(OP_CLEAR, 32'd0);
    cmd(OP_START, 32'd5);
    repeat (4) tick();
    cmd(OP_STOP, 32'd0);
    chk("t4_hold", busy, 0);
    chk("t4_no_done", window_done, 0);
    chk("t4_elapsed5", cycles_elapsed, 5);
    chk("t4_cmd_ready", cmd_ready, 1);
    tick();
    chk("t4_no_done_late", window_done, 0);
    chk("t4_elapsed_hold", cycles_elapsed, 5);

    // 5: resume from HOLD accumulates
    cmd(OP_CLEAR, 32'd0);
    tick();
    issue_in = 1'b1;
    cmd(OP_START, 32'd4);
    repeat (4) tick();
    chk("t5_done_first", window_done, 1);
    chk("t5_elapsed4", cycles_elapsed, 4);
    chk("t5_cnt0_4", cnt0, 4);
    repeat (3) tick();
    chk("t5_hold_elapsed", cycles_elapsed, 4);
    chk("t5_hold_cnt0", cnt0, 4);
    chk("t5_hold_gate", issue_out, 0);
    cmd(OP_START, 32'd3);
    chk("t5_resume_elapsed", cycles_elapsed, 4);
    chk("t5_resume_busy", busy, 1);
    repeat (2) tick();
    chk("t5_not_yet", window_done, 0);
    tick();
    chk("t5_done_second", window_done, 1);
    chk("t5_elapsed7", cycles_elapsed, 7);
    chk("t5_cnt0_7", cnt0, 7);

    // 6: async reset mid-dump, then CLEAR from RUN
    issue_in = 1'b0;
    dump_ready = 1'b1;
    cmd(OP_DUMP, 32'd0);
    repeat (4) tick();
    chk("t6_idx4", dump_index, 4);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", dump_valid, 0);
    chk("t6_rst_enable", prof_enable, 0);
    chk("t6_rst_elapsed", cycles_elapsed, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_index", dump_index, 0);
    tick();
    rst = 1'b0;
    tick();
    cmd(OP_START, 32'd0);
    issue_in = 1'b1;
    repeat (3) tick();
    chk("t6_run_cnt0", cnt0, 3);
    cmd(OP_CLEAR, 32'd0);
    chk("t6_clear_enable", prof_enable, 0);
    chk("t6_clear_elapsed", cycles_elapsed, 0);
    chk("t6_clear_busy", busy, 0);
    chk("t6_clear_gate", issue_out, 0);
    tick();
    chk("t6_cnt0_cleared", cnt0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
